// File: rtl/cla_cntr.sv
// Up/down counter with a chained 4-bit carry-look-ahead datapath, driven by a command FSM.
// Optional clamping at the range ends is enabled with `define CLA_CNTR_SATURATE_EN.
module cla_cntr #(
    parameter int WIDTH    = 8,
    parameter int STEP_BIG = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic             big,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] cnt,
    output logic [2:0]       state,
    output logic             tc_up,
    output logic             tc_dn,
    output logic             sat
);

    localparam int NST = WIDTH / 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_INC  = 3'b010,
        S_INC2 = 3'b011,
        S_DEC  = 3'b100,
        S_DEC2 = 3'b101
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] step, opb, sum;
    logic             is_dec, is_big, cin;
    logic [NST-1:0]   c;

    // Sum of one 4-bit look-ahead block; internal carries come from generate/propagate terms.
    function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g, p;
        logic       c1, c2, c3;
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return p ^ {c3, c2, c1, ci};
    endfunction

    function automatic logic cla4_cout(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g, p;
        g = a & b;
        p = a ^ b;
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
    endfunction

    always_comb begin
        state_d = S_IDLE;
        if (load)      state_d = S_LOAD;
        else if (!en)  state_d = S_IDLE;
        else if (up)   state_d = big ? S_INC2 : S_INC;
        else           state_d = big ? S_DEC2 : S_DEC;
        // Stray codes 110/111 fall back to IDLE regardless of the command inputs.
        if (!(state_q inside {S_IDLE, S_LOAD, S_INC, S_INC2, S_DEC, S_DEC2}))
            state_d = S_IDLE;
    end

    // Decrement is addition of the inverted step with carry-in 1.
    always_comb begin
        is_dec = (state_d == S_DEC) || (state_d == S_DEC2);
        is_big = (state_d == S_INC2) || (state_d == S_DEC2);
        step   = is_big ? WIDTH'(STEP_BIG) : WIDTH'(1);
        opb    = is_dec ? ~step : step;
        cin    = is_dec;
    end

    assign c[0] = cin;

    for (genvar gi = 0; gi < NST; gi++) begin : g_cla
        assign sum[gi*4 +: 4] = cla4_sum(cnt_q[gi*4 +: 4], opb[gi*4 +: 4], c[gi]);
        if (gi < NST - 1) begin : g_carry
            assign c[gi+1] = cla4_cout(cnt_q[gi*4 +: 4], opb[gi*4 +: 4], c[gi]);
        end
    end

`ifdef CLA_CNTR_SATURATE_EN
    logic co, clamp_d, sat_q;

    assign co = cla4_cout(cnt_q[WIDTH-4 +: 4], opb[WIDTH-4 +: 4], c[NST-1]);

    // Increment overflows on carry-out; decrement underflows when no carry comes out.
    always_comb begin
        clamp_d = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_d)
            S_LOAD: cnt_d = d_in;
            S_INC, S_INC2: begin
                clamp_d = co;
                cnt_d   = co ? {WIDTH{1'b1}} : sum;
            end
            S_DEC, S_DEC2: begin
                clamp_d = ~co;
                cnt_d   = co ? sum : {WIDTH{1'b0}};
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sat_q <= 1'b0;
        else          sat_q <= clamp_d;
    end

    assign sat = sat_q;
`else
    always_comb begin
        cnt_d = cnt_q;
        unique case (state_d)
            S_LOAD:                       cnt_d = d_in;
            S_INC, S_INC2, S_DEC, S_DEC2: cnt_d = sum;
            default:                      cnt_d = cnt_q;
        endcase
    end

    assign sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt   = cnt_q;
    assign state = state_q;
    assign tc_up = &cnt_q;
    assign tc_dn = ~|cnt_q;

endmodule

// File: tb/tb_cla_cntr.sv
// Directed bench for cla_cntr (WIDTH=8, STEP_BIG=2) with hand-computed expectations.
module tb_cla_cntr;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load, en, up, big;
    logic [7:0] d_in;
    logic [7:0] cnt;
    logic [2:0] state;
    logic       tc_up, tc_dn, sat;

    int n_cmp = 0;
    int n_bad = 0;

    cla_cntr #(.WIDTH(8), .STEP_BIG(2)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .en(en), .up(up), .big(big),
        .d_in(d_in), .cnt(cnt), .state(state), .tc_up(tc_up), .tc_dn(tc_dn), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply a command at the falling edge, then sample just after the next rising edge.
    task automatic cmd(input logic l, input logic e, input logic u, input logic b, input logic [7:0] d);
        @(negedge clk);
        load = l; en = e; up = u; big = b; d_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cs(input string tag, input logic [7:0] c, input logic [2:0] s);
        chk({tag, ".cnt"}, 32'(cnt), 32'(c));
        chk({tag, ".state"}, 32'(state), 32'(s));
    endtask

    initial begin
        reset_n = 1'b0;
        load = 0; en = 0; up = 0; big = 0; d_in = 8'h00;
        #7;
        expect_cs("reset", 8'h00, 3'b000);
        chk("reset.tc_dn", 32'(tc_dn), 32'd1);
        chk("reset.tc_up", 32'(tc_up), 32'd0);
        chk("reset.sat", 32'(sat), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        cmd(1, 1, 1, 0, 8'h5A); expect_cs("load_prio", 8'h5A, 3'b001);

        cmd(1, 0, 0, 0, 8'h10); expect_cs("load10", 8'h10, 3'b001);
        cmd(0, 1, 1, 0, 8'h00); expect_cs("inc1", 8'h11, 3'b010);
        cmd(0, 1, 1, 0, 8'h00); expect_cs("inc2", 8'h12, 3'b010);
        cmd(0, 1, 1, 0, 8'h00); expect_cs("inc3", 8'h13, 3'b010);
        cmd(0, 1, 1, 1, 8'h00); expect_cs("inc_big", 8'h15, 3'b011);
        cmd(0, 1, 0, 1, 8'h00); expect_cs("dec_big", 8'h13, 3'b101);

`ifndef CLA_CNTR_SATURATE_EN
        cmd(1, 0, 0, 0, 8'hFF); expect_cs("loadFF", 8'hFF, 3'b001);
        chk("loadFF.tc_up", 32'(tc_up), 32'd1);
        cmd(0, 1, 1, 0, 8'h00); expect_cs("wrap_inc", 8'h00, 3'b010);
        chk("wrap_inc.tc_dn", 32'(tc_dn), 32'd1);
        chk("wrap_inc.sat", 32'(sat), 32'd0);
        cmd(1, 0, 0, 0, 8'h01); expect_cs("load01", 8'h01, 3'b001);
        cmd(0, 1, 0, 1, 8'h00); expect_cs("wrap_dec2", 8'hFF, 3'b101);
        chk("wrap_dec2.tc_up", 32'(tc_up), 32'd1);
        chk("wrap_dec2.sat", 32'(sat), 32'd0);
`else
        cmd(1, 0, 0, 0, 8'hFE); expect_cs("loadFE", 8'hFE, 3'b001);
        cmd(0, 1, 1, 1, 8'h00); expect_cs("sat_inc2", 8'hFF, 3'b011);
        chk("sat_inc2.sat", 32'(sat), 32'd1);
        cmd(0, 1, 1, 0, 8'h00); expect_cs("sat_inc", 8'hFF, 3'b010);
        chk("sat_inc.sat", 32'(sat), 32'd1);
        cmd(0, 0, 0, 0, 8'h00); expect_cs("sat_hold", 8'hFF, 3'b000);
        chk("sat_hold.sat", 32'(sat), 32'd0);
        cmd(1, 0, 0, 0, 8'h01); expect_cs("load01", 8'h01, 3'b001);
        cmd(0, 1, 0, 1, 8'h00); expect_cs("sat_dec2", 8'h00, 3'b101);
        chk("sat_dec2.sat", 32'(sat), 32'd1);
        cmd(1, 0, 0, 0, 8'hFF); expect_cs("sat_loadFF", 8'hFF, 3'b001);
`endif

        cmd(0, 1, 0, 0, 8'h00); expect_cs("dec1", 8'hFE, 3'b100);
        chk("dec1.tc_up", 32'(tc_up), 32'd0);
        chk("dec1.tc_dn", 32'(tc_dn), 32'd0);

        for (int i = 0; i < 4; i++) begin
            cmd(0, 0, 1, 1, 8'hAA); expect_cs("hold", 8'hFE, 3'b000);
        end

        cmd(1, 0, 0, 0, 8'h40); expect_cs("load40", 8'h40, 3'b001);
        cmd(0, 1, 1, 0, 8'h00); expect_cs("inc40", 8'h41, 3'b010);
        #2;
        reset_n = 1'b0;
        #1;
        expect_cs("mid_reset", 8'h00, 3'b000);
        chk("mid_reset.tc_dn", 32'(tc_dn), 32'd1);
        chk("mid_reset.sat", 32'(sat), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        expect_cs("post_reset_inc", 8'h01, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_cntr.md
CLA_CNTR -- requirements
Module: cla_cntr

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; SHALL be a multiple of 4, range 4..32.
REQ-002 Parameter STEP_BIG, default 2, step size used in INC2/DEC2 states; SHALL be 1..15.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  load d_in into counter; highest priority command.
REQ-006 en  input  1  count enable; 0 = hold.
REQ-007 up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 big  input  1  step select; 1 = STEP_BIG, 0 = step of 1.
REQ-009 d_in  input  WIDTH  load value.
REQ-010 cnt  output  WIDTH  registered counter value.
REQ-011 state  output  3  registered FSM state code.
REQ-012 tc_up  output  1  combinational; 1 when cnt == 2^WIDTH-1.
REQ-013 tc_dn  output  1  combinational; 1 when cnt == 0.
REQ-014 sat  output  1  registered saturation flag; constant 0 when SATURATE_EN is undefined.

Function
REQ-015 FSM states and codes SHALL be: IDLE=3'b000, LOAD=3'b001, INC=3'b010, INC2=3'b011, DEC=3'b100, DEC2=3'b101; codes 110/111 SHALL be unreachable and SHALL return to IDLE on the next edge.
REQ-016 Next state SHALL be evaluated identically from every state: load=1 -> LOAD; else en=0 -> IDLE; else up=1 -> (big ? INC2 : INC); else (big ? DEC2 : DEC).
REQ-017 cnt SHALL be updated on the same edge as state, per the next state: LOAD -> d_in; IDLE -> hold; INC -> cnt+1; INC2 -> cnt+STEP_BIG; DEC -> cnt-1; DEC2 -> cnt-STEP_BIG.
REQ-018 Latency: a command sampled at edge N SHALL be visible on cnt and state after edge N.
REQ-019 Add/subtract SHALL use a chained 4-bit carry-look-ahead adder datapath of WIDTH/4 stages; subtraction SHALL be implemented as addition of the two's complement (inverted step, carry-in 1).
REQ-020 With SATURATE_EN undefined, arithmetic SHALL wrap modulo 2^WIDTH: for example, 0xFF+1 = 0x00, 0x01-2 = 0xFF.
REQ-021 load together with en/up/big SHALL load d_in and ignore the other commands.
REQ-022 tc_up and tc_dn SHALL follow cnt combinationally, with no register stage.

Reset
REQ-023 reset_n=0 SHALL force, without waiting for clk: cnt=0, state=IDLE, sat=0; tc_dn=1 and tc_up=0 follow from cnt=0.
REQ-024 Reset asserted mid-operation SHALL discard any pending update; the first edge after release SHALL apply REQ-016/REQ-017 from cnt=0, state=IDLE.

Configuration
REQ-025 Macro CLA_CNTR_SATURATE_EN: when defined, an increment whose carry-out is 1 SHALL yield 2^WIDTH-1, and a decrement whose result would fall below 0 SHALL yield 0; sat SHALL be 1 for the cycle after any clamped update and 0 after any unclamped update (LOAD and IDLE clear it).
REQ-026 When CLA_CNTR_SATURATE_EN is undefined, REQ-020 wrap SHALL apply and sat SHALL be tied to 0.

Verification (WIDTH=8, STEP_BIG=2)
REQ-027 Reset: reset_n=0 asynchronously between clock edges -> cnt=0x00, state=000, tc_dn=1, immediately without a clock edge.
REQ-028 Load priority: load=1, en=1, up=1, d_in=0x5A -> next cnt=0x5A, state=001.
REQ-029 Count sequence: from 0x10, en=1, up=1, big=0 for 3 cycles, then big=1 for 1 cycle, then up=0, big=1 for 1 cycle -> cnt 0x11, 0x12, 0x13, 0x15, 0x13; states 010, 010, 010, 011, 101.
REQ-030 Wrap (macro undefined): load 0xFF, then INC -> 0x00, tc_dn=1; load 0x01, then DEC2 -> 0xFF, tc_up=1.
REQ-031 Saturate (macro defined): load 0xFE, then INC2 -> 0xFF, sat=1; then INC -> 0xFF, sat=1; then en=0 -> hold at 0xFF, sat=0; load 0x01, then DEC2 -> 0x00, sat=1.
REQ-032 Hold and reset mid-operation: en=0 for 4 cycles -> cnt is constant and state=000; reset_n pulsed low during counting -> cnt=0x00 at once, and the next INC gives 0x01.
